// File: rtl/spi_master_param.sv
// Parametrised SPI master: one DATA_W word per request, all CPOL/CPHA modes,
// selectable bit order, CS-held bursts and programmable CS setup/hold times.
//
// state   | meaning
// S_IDLE  | CS high, waiting for spi_en
// S_SETUP | CS low for CS_SETUP cycles before the first SCK edge
// S_XFER  | 2*DATA_W SCK edges, one every CLK_DIV cycles
// S_HOLD  | CS low, SCK idle for CS_HOLD cycles, then CS rises
// S_WAIT  | burst pause: CS low, not busy, waiting for the next word
module spi_master_param #(
    parameter int DATA_W    = 8,
    parameter int CLK_DIV   = 4,
    parameter int CPOL      = 0,
    parameter int CPHA      = 0,
    parameter int MSB_FIRST = 1,
    parameter int CS_SETUP  = 2,
    parameter int CS_HOLD   = 2
) (
    input  logic              i_sys_clk,
    input  logic              i_reset_n,
    input  logic              spi_en,
    input  logic              spi_cont,
    input  logic [DATA_W-1:0] tx_data,
    output logic [DATA_W-1:0] rx_data,
    output logic              spi_busy,
    output logic              spi_done,
    output logic              CS,
    output logic              SCK,
    output logic              MOSI,
    input  logic              MISO
);
    localparam int CNT_MAX = (CLK_DIV > CS_SETUP)
                           ? ((CLK_DIV > CS_HOLD) ? CLK_DIV : CS_HOLD)
                           : ((CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD);
    localparam int CNT_W  = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
    localparam int EDGE_W = $clog2(2 * DATA_W);

    localparam logic [CNT_W-1:0]  DIV_LOAD   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]  SETUP_LOAD = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0]  HOLD_LOAD  = CNT_W'(CS_HOLD - 1);
    localparam logic [EDGE_W-1:0] EDGE_LOAD  = EDGE_W'(2 * DATA_W - 1);
    localparam logic              SCK_IDLE   = (CPOL != 0);
    localparam logic              LEAD_SHIFT = (CPHA != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_XFER,
        S_HOLD,
        S_WAIT
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [EDGE_W-1:0]   edge_q, edge_d;
    logic [DATA_W-1:0]   tx_sr_q, tx_sr_d;
    logic [DATA_W-1:0]   rx_sr_q, rx_sr_d;
    logic [DATA_W-1:0]   rx_q, rx_d;
    logic                cont_q, cont_d;
    logic                sck_q, sck_d;
    logic                mosi_q, mosi_d;
    logic                cs_q, cs_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                accept;
    logic                odd_edge;

    function automatic logic first_bit(input logic [DATA_W-1:0] v);
        return (MSB_FIRST != 0) ? v[DATA_W-1] : v[0];
    endfunction

    function automatic logic [DATA_W-1:0] drop_bit(input logic [DATA_W-1:0] v);
        return (MSB_FIRST != 0) ? (v << 1) : (v >> 1);
    endfunction

    function automatic logic [DATA_W-1:0] push_bit(input logic [DATA_W-1:0] v, input logic b);
        return (MSB_FIRST != 0) ? {v[DATA_W-2:0], b} : {b, v[DATA_W-1:1]};
    endfunction

    assign accept   = spi_en && ((state_q == S_IDLE) || (state_q == S_WAIT));
    // edge_q counts down from 2*DATA_W-1, so its parity matches the edge number
    assign odd_edge = edge_q[0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        edge_d  = edge_q;
        tx_sr_d = tx_sr_q;
        rx_sr_d = rx_sr_q;
        rx_d    = rx_q;
        cont_d  = cont_q;
        sck_d   = sck_q;
        mosi_d  = mosi_q;
        done_d  = 1'b0;

        if (accept) begin
            cont_d  = spi_cont;
            tx_sr_d = LEAD_SHIFT ? tx_data : drop_bit(tx_data);
            if (!LEAD_SHIFT) begin
                mosi_d = first_bit(tx_data);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_SETUP;
                    cnt_d   = SETUP_LOAD;
                end
            end
            S_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = S_XFER;
                    cnt_d   = DIV_LOAD;
                    edge_d  = EDGE_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_XFER: begin
                if (cnt_q == '0) begin
                    cnt_d  = DIV_LOAD;
                    sck_d  = ~sck_q;
                    edge_d = edge_q - EDGE_W'(1);
                    if (LEAD_SHIFT ? !odd_edge : odd_edge) begin
                        rx_sr_d = push_bit(rx_sr_q, MISO);
                    end
                    if (LEAD_SHIFT ? odd_edge : (!odd_edge && (edge_q != '0))) begin
                        mosi_d  = first_bit(tx_sr_q);
                        tx_sr_d = drop_bit(tx_sr_q);
                    end
                    if (edge_q == '0) begin
                        if (cont_q) begin
                            state_d = S_WAIT;
                            done_d  = 1'b1;
                            rx_d    = rx_sr_d;
                        end else begin
                            state_d = S_HOLD;
                            cnt_d   = HOLD_LOAD;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    rx_d    = rx_sr_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_WAIT: begin
                if (accept) begin
                    state_d = S_XFER;
                    cnt_d   = DIV_LOAD;
                    edge_d  = EDGE_LOAD;
                end
            end
            default: state_d = S_IDLE;
        endcase

        cs_d   = (state_d == S_IDLE);
        busy_d = (state_d == S_SETUP) || (state_d == S_XFER) || (state_d == S_HOLD);
    end

    always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            edge_q  <= '0;
            tx_sr_q <= '0;
            rx_sr_q <= '0;
            rx_q    <= '0;
            cont_q  <= 1'b0;
            sck_q   <= SCK_IDLE;
            mosi_q  <= 1'b0;
            cs_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            edge_q  <= edge_d;
            tx_sr_q <= tx_sr_d;
            rx_sr_q <= rx_sr_d;
            rx_q    <= rx_d;
            cont_q  <= cont_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
            cs_q    <= cs_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign rx_data  = rx_q;
    assign spi_busy = busy_q;
    assign spi_done = done_q;
    assign CS       = cs_q;
    assign SCK      = sck_q;
    assign MOSI     = mosi_q;

endmodule

// File: tb/tb_spi_master_param.sv
// Bench for spi_master_param: two differently parametrised instances, a
// slave-side pin monitor and a word-level reference model.
module tb_spi_master_param;
    localparam int N = 2;
    localparam int W0 = 8,  D0 = 4, POL0 = 0, PHA0 = 0, MSB0 = 1, SU0 = 2, HO0 = 2;
    localparam int W1 = 16, D1 = 1, POL1 = 1, PHA1 = 1, MSB1 = 0, SU1 = 1, HO1 = 3;
    localparam int P_W    [N] = '{W0, W1};
    localparam int P_DIV  [N] = '{D0, D1};
    localparam int P_CPOL [N] = '{POL0, POL1};
    localparam int P_CPHA [N] = '{PHA0, PHA1};
    localparam int P_MSB  [N] = '{MSB0, MSB1};
    localparam int P_SU   [N] = '{SU0, SU1};
    localparam int P_HO   [N] = '{HO0, HO1};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en [N];
    logic        cont [N];
    logic [15:0] txd [N];
    logic [1:0]  miso_mode [N];
    logic [7:0]  rx0;
    logic [15:0] rx1;
    logic [15:0] rxd [N];
    logic        busy [N], done [N], cs [N], sck [N], mosi [N], miso [N];

    int checks = 0;
    int errors = 0;

    int          sck_rise [N]  = '{default: 0};
    int          sck_edges [N] = '{default: 0};
    int          bits [N]      = '{default: 0};
    int          cs_rise [N]   = '{default: 0};
    int          cs_low [N]    = '{default: 0};
    int          done_n [N]    = '{default: 0};
    int          idle_err [N]  = '{default: 0};
    int          mosi_bad [N]  = '{default: 0};
    logic [63:0] hist [N]      = '{default: 64'h0};
    logic        sck_p [N], cs_p [N], mosi_p [N];
    logic        rst_p = 1'b0;
    logic        lead_v, edge_v;

    always #5 clk = ~clk;

    assign rxd[0]  = {8'h00, rx0};
    assign rxd[1]  = rx1;
    // mode 0: MISO looped from MOSI, 1: constant 0, 2: constant 1
    assign miso[0] = (miso_mode[0] == 2'd0) ? mosi[0] : (miso_mode[0] == 2'd2);
    assign miso[1] = (miso_mode[1] == 2'd0) ? mosi[1] : (miso_mode[1] == 2'd2);

    spi_master_param #(.DATA_W(W0), .CLK_DIV(D0), .CPOL(POL0), .CPHA(PHA0),
                       .MSB_FIRST(MSB0), .CS_SETUP(SU0), .CS_HOLD(HO0)) u0 (
        .i_sys_clk(clk), .i_reset_n(rst_n), .spi_en(en[0]), .spi_cont(cont[0]),
        .tx_data(txd[0][7:0]), .rx_data(rx0), .spi_busy(busy[0]), .spi_done(done[0]),
        .CS(cs[0]), .SCK(sck[0]), .MOSI(mosi[0]), .MISO(miso[0]));

    spi_master_param #(.DATA_W(W1), .CLK_DIV(D1), .CPOL(POL1), .CPHA(PHA1),
                       .MSB_FIRST(MSB1), .CS_SETUP(SU1), .CS_HOLD(HO1)) u1 (
        .i_sys_clk(clk), .i_reset_n(rst_n), .spi_en(en[1]), .spi_cont(cont[1]),
        .tx_data(txd[1]), .rx_data(rx1), .spi_busy(busy[1]), .spi_done(done[1]),
        .CS(cs[1]), .SCK(sck[1]), .MOSI(mosi[1]), .MISO(miso[1]));

    // Slave-eye view of the pins: MOSI is captured on the edge the slave samples.
    always @(negedge clk) begin
        for (int g = 0; g < N; g++) begin
            edge_v = (sck[g] != sck_p[g]) && !cs[g] && !cs_p[g];
            lead_v = (sck[g] != (P_CPOL[g] != 0));
            if (rst_n && rst_p) begin
                if (edge_v) begin
                    sck_edges[g]++;
                    if (sck[g]) sck_rise[g]++;
                    if (lead_v == (P_CPHA[g] == 0)) begin
                        hist[g] = {hist[g][62:0], mosi[g]};
                        bits[g]++;
                    end
                end
                if (cs[g] && (sck[g] != (P_CPOL[g] != 0))) idle_err[g]++;
                if ((P_CPHA[g] != 0) && (mosi[g] != mosi_p[g]) && !(edge_v && lead_v)) mosi_bad[g]++;
                if (cs[g] && !cs_p[g]) cs_rise[g]++;
                if (!cs[g]) cs_low[g]++;
                if (done[g]) done_n[g]++;
            end
            sck_p[g]  = sck[g];
            cs_p[g]   = cs[g];
            mosi_p[g] = mosi[g];
        end
        rst_p = rst_n;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic string tg(input int i, input string s);
        return $sformatf("u%0d_%s", i, s);
    endfunction

    function automatic logic [31:0] mask(input int i);
        return (32'd1 << P_W[i]) - 32'd1;
    endfunction

    // Bits in wire order, first bit transmitted placed at position W-1.
    function automatic logic [31:0] order(input int i, input logic [15:0] v);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < P_W[i]; k++) begin
            if (P_MSB[i] != 0) r[k] = v[k];
            else               r[P_W[i]-1-k] = v[k];
        end
        return r;
    endfunction

    function automatic logic [31:0] exp_rx(input int i, input int mode, input logic [15:0] tx);
        if (mode == 0) return 32'(tx) & mask(i);
        if (mode == 1) return 32'd0;
        return mask(i);
    endfunction

    function automatic int lat_word(input int i, input logic first, input logic c);
        return 1 + (first ? P_SU[i] : 0) + 2 * P_DIV[i] * P_W[i] + (c ? 0 : P_HO[i]);
    endfunction

    task automatic issue(input int i, input logic [15:0] tx, input logic c);
        txd[i]  = tx;
        cont[i] = c;
        en[i]   = 1'b1;
        @(posedge clk);
        #1;
        en[i]   = 1'b0;
        txd[i]  = 16'($urandom);
        cont[i] = 1'($urandom);
    endtask

    task automatic wait_done(input int i, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            #1;
            lat++;
        end while (!done[i] && lat < 3000);
        check_val(tg(i, "done_seen"), 32'(done[i]), 32'd1);
    endtask

    task automatic run_word(input int i, input logic [15:0] tx, input logic c,
                            input logic first, input int mode);
        int b0, r0, lat;
        miso_mode[i] = 2'(mode);
        b0 = bits[i];
        r0 = sck_rise[i];
        issue(i, tx, c);
        wait_done(i, lat);
        check_val(tg(i, "latency"), 32'(lat), 32'(lat_word(i, first, c)));
        check_val(tg(i, "rx"), 32'(rxd[i]), exp_rx(i, mode, tx));
        check_val(tg(i, "mosi_bits"), hist[i][31:0] & mask(i), order(i, tx));
        check_val(tg(i, "nbits"), 32'(bits[i] - b0), 32'(P_W[i]));
        check_val(tg(i, "sck_rise"), 32'(sck_rise[i] - r0), 32'(P_W[i]));
        check_val(tg(i, "busy_at_done"), 32'(busy[i]), 32'd0);
        check_val(tg(i, "cs_at_done"), 32'(cs[i]), 32'(!c));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int s_low, s_done, s_rise, s_csr, s_bits, s_edges, lat;
        logic reached;

        for (int i = 0; i < N; i++) begin
            en[i] = 1'b0; cont[i] = 1'b0; txd[i] = 16'h0; miso_mode[i] = 2'd0;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            check_val(tg(i, "rst_cs"),   32'(cs[i]),   32'd1);
            check_val(tg(i, "rst_sck"),  32'(sck[i]),  32'(P_CPOL[i]));
            check_val(tg(i, "rst_mosi"), 32'(mosi[i]), 32'd0);
            check_val(tg(i, "rst_rx"),   32'(rxd[i]),  32'd0);
            check_val(tg(i, "rst_busy"), 32'(busy[i]), 32'd0);
            check_val(tg(i, "rst_done"), 32'(done[i]), 32'd0);
        end
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;

        // single default word, MISO tied high
        s_low = cs_low[0];
        s_done = done_n[0];
        run_word(0, 16'h00AA, 1'b0, 1'b1, 2);
        check_val("u0_cs_low_cycles", 32'(cs_low[0] - s_low), 32'(lat_word(0, 1'b1, 1'b0) - 1));
        check_val("u0_done_pulses", 32'(done_n[0] - s_done), 32'd1);

        // LSB-first, CPOL=1/CPHA=1, loopback
        run_word(1, 16'h8001, 1'b0, 1'b1, 0);
        run_word(1, 16'h5A5A, 1'b0, 1'b1, 0);

        // three-word burst issued on each spi_done
        s_csr = cs_rise[0]; s_done = done_n[0]; s_rise = sck_rise[0]; s_bits = bits[0];
        run_word(0, 16'h0011, 1'b1, 1'b1, 0);
        run_word(0, 16'h0022, 1'b1, 1'b0, 0);
        run_word(0, 16'h0033, 1'b0, 1'b0, 0);
        check_val("u0_burst_cs_rises", 32'(cs_rise[0] - s_csr), 32'd1);
        check_val("u0_burst_done", 32'(done_n[0] - s_done), 32'd3);
        check_val("u0_burst_sck_rise", 32'(sck_rise[0] - s_rise), 32'd24);
        check_val("u0_burst_nbits", 32'(bits[0] - s_bits), 32'd24);
        check_val("u0_burst_stream", hist[0][31:0] & 32'h00FF_FFFF, 32'h0011_2233);

        // asynchronous reset after three SCK edges
        miso_mode[0] = 2'd0;
        s_edges = sck_edges[0];
        issue(0, 16'h00C3, 1'b0);
        reached = 1'b0;
        for (int n = 0; n < 200 && !reached; n++) begin
            @(negedge clk);
            #1;
            reached = (sck_edges[0] - s_edges) >= 3;
        end
        check_val("u0_edges_before_rst", 32'(reached), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("u0_arst_cs",   32'(cs[0]),   32'd1);
        check_val("u0_arst_sck",  32'(sck[0]),  32'(P_CPOL[0]));
        check_val("u0_arst_busy", 32'(busy[0]), 32'd0);
        check_val("u0_arst_rx",   32'(rxd[0]),  32'd0);
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        run_word(0, 16'h00C3, 1'b0, 1'b1, 0);

        // spi_en held high; tx_data changed mid-transfer
        miso_mode[0] = 2'd0;
        s_bits = bits[0];
        txd[0] = 16'h00F0; cont[0] = 1'b0; en[0] = 1'b1;
        @(posedge clk);
        #1;
        repeat (10) begin
            @(negedge clk);
            #1;
        end
        txd[0] = 16'h000F;
        wait_done(0, lat);
        check_val("u0_held_lat1", 32'(lat), 32'(lat_word(0, 1'b1, 1'b0) - 10));
        check_val("u0_held_rx1", 32'(rxd[0]), 32'h0000_00F0);
        check_val("u0_held_cs_done", 32'(cs[0]), 32'd1);
        @(negedge clk);
        #1;
        check_val("u0_held_cs_relow", 32'(cs[0]), 32'd0);
        check_val("u0_held_busy", 32'(busy[0]), 32'd1);
        en[0] = 1'b0;
        wait_done(0, lat);
        check_val("u0_held_lat2", 32'(lat), 32'(lat_word(0, 1'b1, 1'b0) - 1));
        check_val("u0_held_rx2", 32'(rxd[0]), 32'h0000_000F);
        check_val("u0_held_stream", hist[0][31:0] & 32'h0000_FFFF, 32'h0000_F00F);
        check_val("u0_held_nbits", 32'(bits[0] - s_bits), 32'd16);

        // randomized bursts on both instances
        for (int r = 0; r < 30; r++) begin
            int ri, len, gap;
            ri  = int'($urandom_range(0, 1));
            len = int'($urandom_range(1, 3));
            for (int k = 0; k < len; k++) begin
                run_word(ri, 16'($urandom) & 16'(mask(ri)), (k < len - 1), (k == 0),
                         int'($urandom_range(0, 2)));
            end
            gap = int'($urandom_range(0, 3));
            repeat (gap) begin
                @(negedge clk);
                #1;
            end
        end

        for (int i = 0; i < N; i++) begin
            check_val(tg(i, "sck_idle_level"), 32'(idle_err[i]), 32'd0);
        end
        check_val("u1_mosi_on_leading", 32'(mosi_bad[1]), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
